// File: rtl/cursor_gain_apply_sched.sv
// Scales raw (dx, dy) motion by a clamped Q8.8 gain. One shared 8x16 multiplier
// serves X then Y, and a per-axis fractional residual carries sub-pixel motion.
module cursor_gain_apply_sched #(
  parameter logic signed [15:0] GAIN_MIN    = 16'sd64,
  parameter logic signed [15:0] GAIN_MAX    = 16'sd1024,
  parameter logic signed [7:0]  OUT_MAX     = 8'sd127,
  parameter bit                 RESIDUAL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0]  in_dx,
  input  logic signed [7:0]  in_dy,
  input  logic signed [15:0] gain_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0]  out_dx,
  output logic signed [7:0]  out_dy,
  output logic              sat_flag,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL_X = 2'd1;
  localparam logic [1:0] ST_MUL_Y = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic signed [16:0] Q_MAX = {{9{OUT_MAX[7]}}, OUT_MAX};
  localparam logic signed [16:0] Q_MIN = -Q_MAX;

  logic [1:0]         state_r, next_state_s;
  logic signed [7:0]  dx_r, dy_r;
  logic signed [15:0] gain_r;
  logic [7:0]         res_x_r, res_y_r;
  logic               in_ready_r, out_valid_r, sat_flag_r, busy_r;
  logic signed [7:0]  out_dx_r, out_dy_r;

  logic               accept_s;
  logic signed [23:0] mul_d_s, mul_g_s, prod_s;
  logic [7:0]         mul_r_s, new_res_s;
  logic signed [24:0] sum_s;
  logic signed [16:0] q_s;
  logic               sat_s;
  logic signed [7:0]  axis_out_s;

  function automatic logic signed [15:0] clamp_gain(input logic signed [15:0] g);
    if (g < GAIN_MIN)      return GAIN_MIN;
    else if (g > GAIN_MAX) return GAIN_MAX;
    else                   return g;
  endfunction

  assign accept_s = in_valid && in_ready_r;

  // Shared multiplier datapath: operand select, residual add, floor and saturate.
  always_comb begin
    mul_d_s    = 24'sd0;
    mul_r_s    = 8'd0;
    axis_out_s = 8'sd0;
    sat_s      = 1'b0;
    if (state_r == ST_MUL_Y) begin
      mul_d_s = {{16{dy_r[7]}}, dy_r};
      mul_r_s = res_y_r;
    end else begin
      mul_d_s = {{16{dx_r[7]}}, dx_r};
      mul_r_s = res_x_r;
    end
    mul_g_s = {{8{gain_r[15]}}, gain_r};
    prod_s  = mul_d_s * mul_g_s;
    if (RESIDUAL_EN) begin
      sum_s = {prod_s[23], prod_s} + {17'd0, mul_r_s};
    end else begin
      sum_s = {prod_s[23], prod_s} + 25'sd128;
    end
    q_s = sum_s[24:8];
    if (q_s > Q_MAX) begin
      axis_out_s = OUT_MAX;
      sat_s      = 1'b1;
    end else if (q_s < Q_MIN) begin
      axis_out_s = Q_MIN[7:0];
      sat_s      = 1'b1;
    end else begin
      axis_out_s = q_s[7:0];
    end
    if (sat_s || !RESIDUAL_EN) begin
      new_res_s = 8'd0;
    end else begin
      new_res_s = sum_s[7:0];
    end
  end

  // Sequencer next-state: IDLE -> MUL_X -> MUL_Y -> OUT -> IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) next_state_s = ST_MUL_X; else next_state_s = ST_IDLE;
      ST_MUL_X: next_state_s = ST_MUL_Y;
      ST_MUL_Y: next_state_s = ST_OUT;
      ST_OUT:   if (out_ready) next_state_s = ST_IDLE; else next_state_s = ST_OUT;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // State, operand latch and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      dx_r        <= 8'sd0;
      dy_r        <= 8'sd0;
      gain_r      <= 16'sd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_dx_r    <= 8'sd0;
      out_dy_r    <= 8'sd0;
      sat_flag_r  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == ST_IDLE);
      out_valid_r <= (next_state_s == ST_OUT);
      busy_r      <= (next_state_s != ST_IDLE);
      if (accept_s) begin
        dx_r   <= in_dx;
        dy_r   <= in_dy;
        gain_r <= clamp_gain(gain_in);
      end
      case (state_r)
        ST_MUL_X: begin
          out_dx_r   <= axis_out_s;
          sat_flag_r <= sat_s;
        end
        ST_MUL_Y: begin
          out_dy_r   <= axis_out_s;
          sat_flag_r <= sat_flag_r | sat_s;
        end
        default: ;
      endcase
    end
  end

  // Residuals: flush wins over the update made by the axis computed this cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      res_x_r <= 8'd0;
      res_y_r <= 8'd0;
    end else if (state_r == ST_MUL_X) begin
      res_x_r <= new_res_s;
    end else if (state_r == ST_MUL_Y) begin
      res_y_r <= new_res_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_dx    = out_dx_r;
  assign out_dy    = out_dy_r;
  assign sat_flag  = sat_flag_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cursor_gain_apply_sched.sv
// Directed bench for cursor_gain_apply_sched: a residual-tracking model pushes
// expected samples to a scoreboard queue, popped when the DUT presents output.
module tb_cursor_gain_apply_sched;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, flush, out_valid, out_ready, sat_flag, busy;
  logic signed [7:0]  in_dx, in_dy, out_dx, out_dy;
  logic signed [15:0] gain_in;

  typedef struct { int dx; int dy; int sat; } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;
  int mrx = 0, mry = 0;
  int lat;

  cursor_gain_apply_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dx(in_dx), .in_dy(in_dy), .gain_in(gain_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_dx(out_dx),
    .out_dy(out_dy), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_g(input int g);
    if (g < 64) return 64;
    if (g > 1024) return 1024;
    return g;
  endfunction

  function automatic int axis(input int d, input int g, inout int r, inout int sat);
    int s, q;
    s = d * g + r;
    q = s >>> 8;
    r = s & 255;
    if (q > 127) begin q = 127; r = 0; sat = 1; end
    else if (q < -127) begin q = -127; r = 0; sat = 1; end
    return q;
  endfunction

  // Push the expected result; flush_mx models a flush during the MUL_X cycle.
  task automatic model_push(input int dx, input int dy, input int g, input bit flush_mx);
    exp_t e;
    int gc;
    gc = clamp_g(g);
    e.sat = 0;
    e.dx = axis(dx, gc, mrx, e.sat);
    if (flush_mx) begin mrx = 0; mry = 0; end
    e.dy = axis(dy, gc, mry, e.sat);
    sb_q.push_back(e);
  endtask

  // Offer a sample and return #1 after the accepting edge (DUT then in MUL_X).
  task automatic send(input int dx, input int dy, input int g, input bit push, input bit flush_mx);
    int n;
    @(negedge clk);
    in_dx = dx[7:0]; in_dy = dy[7:0]; gain_in = g[15:0]; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_wait", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) model_push(dx, dy, g, flush_mx);
  endtask

  // Wait for output, compare against the scoreboard, hold out_ready low for hold cycles.
  task automatic recv(input string tag, input int hold, output int latency);
    exp_t e;
    latency = 0;
    do begin @(negedge clk); latency++; end while (!out_valid && latency < 20);
    chk({tag, "_valid"}, int'(out_valid), 1);
    assert (sb_q.size() > 0) else begin
      miscompares++;
      $error("FAIL %s_sb: scoreboard empty", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_dx"}, int'(out_dx), e.dx);
      chk({tag, "_dy"}, int'(out_dy), e.dy);
      chk({tag, "_sat"}, int'(sat_flag), e.sat);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, int'(out_valid), 1);
        chk({tag, "_hold_dx"}, int'(out_dx), e.dx);
        chk({tag, "_hold_dy"}, int'(out_dy), e.dy);
        chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, int'(out_valid), 0);
    chk({tag, "_post_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_dx = 8'sd0; in_dy = 8'sd0; gain_in = 16'sd256;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_dx", int'(out_dx), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Unity gain with exact latency
    send(5, -3, 256, 1'b1, 1'b0);
    recv("unity", 0, lat);
    chk("unity_latency", lat, 3);

    // Fractional carry at gain 0.5
    for (int i = 0; i < 4; i++) begin send(1, 0, 128, 1'b1, 1'b0); recv("carry_pos", 0, lat); end
    for (int i = 0; i < 2; i++) begin send(-1, 0, 128, 1'b1, 1'b0); recv("carry_neg", 0, lat); end

    // Saturation, then residual confirmed cleared
    send(100, -50, 1024, 1'b1, 1'b0); recv("sat", 0, lat);
    send(1, 0, 256, 1'b1, 1'b0);      recv("post_sat", 0, lat);

    // Gain clamps both ends
    send(10, 0, 2000, 1'b1, 1'b0); recv("clamp_hi", 0, lat);
    send(8, 0, 10, 1'b1, 1'b0);    recv("clamp_lo", 0, lat);
    send(3, 2, -500, 1'b1, 1'b0);  recv("clamp_neg", 0, lat);

    // Backpressure with pending input, and gain change during MUL_X
    send(7, -7, 256, 1'b1, 1'b0);
    gain_in = 16'sd1024;
    in_valid = 1'b1; in_dx = 8'sd9; in_dy = 8'sd9;
    recv("bp", 5, lat);
    @(negedge clk);
    chk("bp_not_accepted", int'(busy), 0);

    // Flush during MUL_X with both residuals at 128
    send(1, 1, 128, 1'b1, 1'b0); recv("prime", 0, lat);
    send(1, 1, 128, 1'b1, 1'b1);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    recv("flush", 0, lat);
    send(1, 1, 128, 1'b1, 1'b0); recv("after_flush", 0, lat);

    // Reset in MUL_Y abandons the sample and clears residuals
    send(1, 1, 128, 1'b1, 1'b0); recv("prime2", 0, lat);
    send(5, 5, 256, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mrx = 0; mry = 0;
    @(negedge clk);
    chk("rst_mid_in_ready_lo", int'(in_ready), 0);
    chk("rst_mid_valid0", int'(out_valid), 0);
    @(negedge clk);
    chk("rst_mid_in_ready_hi", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_no_valid", int'(out_valid), 0);
    end
    send(1, 1, 128, 1'b1, 1'b0); recv("after_rst", 0, lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
